// File: rtl/easyaxi_mst_pkg.sv
// Shared AXI widths, encodings and the request-sequence helper for the
// EasyAXI read master.
package easyaxi_mst_pkg;

    localparam int unsigned AXI_ID_W    = 4;
    localparam int unsigned AXI_ADDR_W  = 32;
    localparam int unsigned AXI_LEN_W   = 8;
    localparam int unsigned AXI_SIZE_W  = 3;
    localparam int unsigned AXI_BURST_W = 2;
    localparam int unsigned AXI_DATA_W  = 32;
    localparam int unsigned AXI_RESP_W  = 2;

    typedef enum logic [AXI_BURST_W-1:0] {
        BURST_FIXED = 2'd0,
        BURST_INCR  = 2'd1,
        BURST_WRAP  = 2'd2
    } axi_burst_e;

    typedef enum logic [AXI_RESP_W-1:0] {
        RESP_OKAY   = 2'd0,
        RESP_EXOKAY = 2'd1,
        RESP_SLVERR = 2'd2,
        RESP_DECERR = 2'd3
    } axi_resp_e;

    typedef struct packed {
        logic [AXI_ID_W-1:0]  id;
        logic [AXI_LEN_W-1:0] len;
    } ost_ent_t;

    // WRAP bursts need 2/4/8/16 beats, so odd requests with 6 beats fall back to 4.
    function automatic logic [AXI_LEN_W-1:0] req_len(input logic [7:0] k);
        logic [2:0] l;
        l = k[2:0];
        if (k[0] && (l == 3'd5)) begin
            l = 3'd3;
        end
        return AXI_LEN_W'(l);
    endfunction

endpackage

// File: rtl/easyaxi_mst_if.sv
// AR/R channel bundle between the EasyAXI read master and its slave.
interface easyaxi_mst_if;
    import easyaxi_mst_pkg::*;

    logic                   arvalid;
    logic                   arready;
    logic [AXI_ID_W-1:0]    arid;
    logic [AXI_ADDR_W-1:0]  araddr;
    logic [AXI_LEN_W-1:0]   arlen;
    logic [AXI_SIZE_W-1:0]  arsize;
    logic [AXI_BURST_W-1:0] arburst;

    logic                   rvalid;
    logic                   rready;
    logic [AXI_ID_W-1:0]    rid;
    logic [AXI_DATA_W-1:0]  rdata;
    logic [AXI_RESP_W-1:0]  rresp;
    logic                   rlast;

    modport master (
        output arvalid, arid, araddr, arlen, arsize, arburst, rready,
        input  arready, rvalid, rid, rdata, rresp, rlast
    );

    modport slave (
        input  arvalid, arid, araddr, arlen, arsize, arburst, rready,
        output arready, rvalid, rid, rdata, rresp, rlast
    );

endinterface

// File: rtl/easyaxi_ost_fifo.sv
// Tracking FIFO for outstanding reads: holds {id, len} of each accepted AR
// until its last R beat.
module easyaxi_ost_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int unsigned     AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned     CW       = $clog2(DEPTH + 1);
    localparam logic [AW-1:0]   LAST_IDX = AW'(DEPTH - 1);
    localparam logic [CW-1:0]   FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             push_ok, pop_ok;

    assign full_o  = (cnt_q == FULL_CNT);
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rptr_q];

    always_comb begin
        push_ok = push_i && (!full_o || pop_i);
        pop_ok  = pop_i && !empty_o;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        cnt_d   = cnt_q;
        if (push_ok) begin
            wptr_d = (wptr_q == LAST_IDX) ? '0 : wptr_q + AW'(1);
        end
        if (pop_ok) begin
            rptr_d = (rptr_q == LAST_IDX) ? '0 : rptr_q + AW'(1);
        end
        if (push_ok && !pop_ok) begin
            cnt_d = cnt_q + CW'(1);
        end else if (pop_ok && !push_ok) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            if (push_ok) begin
                mem_q[wptr_q] <= data_i;
            end
        end
    end

endmodule

// File: rtl/easyaxi_mst.sv
// EasyAXI read master: issues a fixed AR burst sequence with bounded
// outstanding reads and checks every returned R beat.
module easyaxi_mst
    import easyaxi_mst_pkg::*;
#(
    parameter int unsigned           OST_DEPTH = 4,
    parameter int unsigned           REQ_NUM   = 8,
    parameter logic [AXI_ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enable,
    easyaxi_mst_if.master axi_mst,
    output logic          rd_done,
    output logic          rd_err
);
    localparam int unsigned    OCW     = $clog2(OST_DEPTH + 1);
    localparam logic [7:0]     REQ_MAX = 8'(REQ_NUM);
    localparam logic [OCW-1:0] OST_MAX = OCW'(OST_DEPTH);

    logic                   arvalid_q, arvalid_d;
    logic [AXI_ID_W-1:0]    arid_q, arid_d;
    logic [AXI_ADDR_W-1:0]  araddr_q, araddr_d;
    logic [AXI_LEN_W-1:0]   arlen_q, arlen_d;
    logic [AXI_SIZE_W-1:0]  arsize_q, arsize_d;
    logic [AXI_BURST_W-1:0] arburst_q, arburst_d;
    logic                   rready_q;
    logic [7:0]             issued_q, issued_d, completed_q, completed_d;
    logic [OCW-1:0]         ost_q, ost_d;
    logic [AXI_LEN_W-1:0]   beat_q, beat_d;
    logic                   done_q, done_d, err_q, err_d;

    logic     ar_hs, r_hs, r_take, pop, hold, err_now;
    logic     fifo_full, fifo_empty;
    ost_ent_t head;

    assign ar_hs  = arvalid_q && axi_mst.arready;
    assign r_hs   = axi_mst.rvalid && rready_q;
    assign r_take = r_hs && !fifo_empty;
    // The slave's RLAST closes the burst; a misplaced RLAST is flagged, not re-framed.
    assign pop    = r_take && axi_mst.rlast;
    assign hold   = arvalid_q && !axi_mst.arready;

    easyaxi_ost_fifo #(
        .DEPTH(OST_DEPTH),
        .WIDTH($bits(ost_ent_t))
    ) u_ost_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push_i (ar_hs),
        .pop_i  (pop),
        .data_i ({arid_q, arlen_q}),
        .head_o (head),
        .full_o (fifo_full),
        .empty_o(fifo_empty)
    );

    always_comb begin
        issued_d    = issued_q;
        completed_d = completed_q;
        ost_d       = ost_q;
        beat_d      = beat_q;
        arvalid_d   = arvalid_q;
        arid_d      = arid_q;
        araddr_d    = araddr_q;
        arlen_d     = arlen_q;
        arsize_d    = arsize_q;
        arburst_d   = arburst_q;

        if (ar_hs && (issued_q < REQ_MAX)) begin
            issued_d = issued_q + 8'd1;
        end
        if (pop && (completed_q < REQ_MAX)) begin
            completed_d = completed_q + 8'd1;
        end
        if (ar_hs && !pop && !fifo_full) begin
            ost_d = ost_q + OCW'(1);
        end else if (pop && !ar_hs) begin
            ost_d = ost_q - OCW'(1);
        end
        if (r_take) begin
            if (axi_mst.rlast) begin
                beat_d = '0;
            end else if (beat_q != '1) begin
                beat_d = beat_q + AXI_LEN_W'(1);
            end
        end

        err_now = r_hs && (fifo_empty ||
                           (axi_mst.rid != head.id) ||
                           (axi_mst.rresp != RESP_OKAY) ||
                           (axi_mst.rlast != (beat_q == head.len)));
        err_d   = err_q || err_now;
        done_d  = done_q || (completed_d == REQ_MAX);

        // Post-update counts let a request follow a handshake or a pop back-to-back.
        arvalid_d = hold || (enable && (issued_d < REQ_MAX) && (ost_d < OST_MAX));
        if (!hold && arvalid_d) begin
            arid_d    = issued_d[AXI_ID_W-1:0];
            araddr_d  = BASE_ADDR + AXI_ADDR_W'({issued_d, 6'd0});
            arlen_d   = req_len(issued_d);
            arsize_d  = AXI_SIZE_W'(2);
            arburst_d = issued_d[0] ? BURST_WRAP : BURST_INCR;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arvalid_q   <= 1'b0;
            arid_q      <= '0;
            araddr_q    <= '0;
            arlen_q     <= '0;
            arsize_q    <= '0;
            arburst_q   <= '0;
            rready_q    <= 1'b0;
            issued_q    <= '0;
            completed_q <= '0;
            ost_q       <= '0;
            beat_q      <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            arvalid_q   <= arvalid_d;
            arid_q      <= arid_d;
            araddr_q    <= araddr_d;
            arlen_q     <= arlen_d;
            arsize_q    <= arsize_d;
            arburst_q   <= arburst_d;
            rready_q    <= enable;
            issued_q    <= issued_d;
            completed_q <= completed_d;
            ost_q       <= ost_d;
            beat_q      <= beat_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign axi_mst.arvalid = arvalid_q;
    assign axi_mst.arid    = arid_q;
    assign axi_mst.araddr  = araddr_q;
    assign axi_mst.arlen   = arlen_q;
    assign axi_mst.arsize  = arsize_q;
    assign axi_mst.arburst = arburst_q;
    assign axi_mst.rready  = rready_q;
    assign rd_done         = done_q;
    assign rd_err          = err_q;

endmodule

// File: tb/tb_easyaxi_mst.sv
// Directed bench for easyaxi_mst: a behavioural read slave answers each AR
// in order while the bench checks AR payloads, throttling, errors and reset.
module tb_easyaxi_mst;
    import easyaxi_mst_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic enable;
    logic rd_done, rd_err;

    easyaxi_mst_if axi ();

    easyaxi_mst #(
        .OST_DEPTH(4),
        .REQ_NUM  (8),
        .BASE_ADDR(32'h0)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .axi_mst(axi.master),
        .rd_done(rd_done),
        .rd_err (rd_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned k;
        int unsigned len;
    } burst_t;

    int unsigned n_checks = 0;
    int unsigned n_errs   = 0;
    int unsigned EXP_LEN [8] = '{0, 1, 2, 3, 4, 3, 6, 7};

    burst_t      rq[$];
    int unsigned ar_cnt, beat_idx, beat_total, max_ost, inj_seen;
    bit          ar_rdy_en, r_en;
    int unsigned inj_kind, inj_req, inj_beat;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_arvalid"}, 64'(axi.arvalid), 0);
        check({tag, "_arid"},    64'(axi.arid),    0);
        check({tag, "_araddr"},  64'(axi.araddr),  0);
        check({tag, "_arlen"},   64'(axi.arlen),   0);
        check({tag, "_arsize"},  64'(axi.arsize),  0);
        check({tag, "_arburst"}, 64'(axi.arburst), 0);
        check({tag, "_rready"},  64'(axi.rready),  0);
        check({tag, "_rd_done"}, 64'(rd_done),     0);
        check({tag, "_rd_err"},  64'(rd_err),      0);
    endtask

    // One clock of the slave model; entered and left at posedge+1.
    task automatic step();
        bit   ar_hs, r_hs, inj_now;
        logic last;
        axi.arready = ar_rdy_en;
        ar_hs = axi.arvalid && ar_rdy_en;
        if (ar_hs) begin
            check($sformatf("arid%0d", ar_cnt),    64'(axi.arid),    64'(ar_cnt % 16));
            check($sformatf("araddr%0d", ar_cnt),  64'(axi.araddr),  64'(ar_cnt * 64));
            check($sformatf("arlen%0d", ar_cnt),   64'(axi.arlen),   64'(EXP_LEN[ar_cnt % 8]));
            check($sformatf("arsize%0d", ar_cnt),  64'(axi.arsize),  64'd2);
            check($sformatf("arburst%0d", ar_cnt), 64'(axi.arburst), (ar_cnt % 2 == 1) ? 64'd2 : 64'd1);
        end
        inj_now = 1'b0;
        if (r_en && rq.size() > 0) begin
            last    = (beat_idx == rq[0].len);
            inj_now = (inj_kind != 0) && (rq[0].k == inj_req) && (beat_idx == inj_beat);
            axi.rvalid = 1'b1;
            axi.rid    = 4'(rq[0].k);
            axi.rdata  = 32'(beat_total);
            axi.rresp  = (inj_now && inj_kind == 1) ? RESP_SLVERR : RESP_OKAY;
            axi.rlast  = last || (inj_now && inj_kind == 2);
        end else begin
            axi.rvalid = 1'b0;
            axi.rlast  = 1'b0;
        end
        r_hs = axi.rvalid && axi.rready;
        if (inj_now && r_hs) begin
            inj_seen++;
            check("err_before_inj", 64'(rd_err), 0);
        end
        @(posedge clk);
        if (ar_hs) begin
            rq.push_back('{k: ar_cnt, len: EXP_LEN[ar_cnt % 8]});
            ar_cnt++;
        end
        if (r_hs) begin
            beat_total++;
            if (axi.rlast) begin
                void'(rq.pop_front());
                beat_idx = 0;
            end else begin
                beat_idx++;
            end
        end
        if (rq.size() > max_ost) max_ost = rq.size();
        #1;
        if (inj_now && r_hs) check("err_after_inj", 64'(rd_err), 1);
    endtask

    task automatic clear_model();
        rq.delete();
        ar_cnt     = 0;
        beat_idx   = 0;
        beat_total = 0;
        max_ost    = 0;
        inj_seen   = 0;
        axi.arready = 1'b0;
        axi.rvalid  = 1'b0;
        axi.rlast   = 1'b0;
        axi.rid     = '0;
        axi.rresp   = '0;
        axi.rdata   = '0;
    endtask

    task automatic do_reset(input string tag);
        rst_n     = 1'b0;
        enable    = 1'b0;
        ar_rdy_en = 1'b1;
        r_en      = 1'b1;
        inj_kind  = 0;
        inj_req   = 0;
        inj_beat  = 0;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs(tag);
        rst_n = 1'b1;
    endtask

    task automatic run_to_done(input string tag, input int unsigned exp_beats);
        for (int i = 0; i < 400 && !rd_done; i++) step();
        check({tag, "_done"}, 64'(rd_done), 1);
        repeat (3) step();
        check({tag, "_ar_cnt"}, 64'(ar_cnt), 8);
        check({tag, "_beats"}, 64'(beat_total), 64'(exp_beats));
    endtask

    initial begin
        // Full sequence, slave always ready: 1+2+3+4+5+4+7+8 beats.
        do_reset("rst0");
        enable = 1'b1;
        step();
        check("arvalid_first", 64'(axi.arvalid), 1);
        check("rready_first", 64'(axi.rready), 1);
        run_to_done("full", 34);
        check("full_err", 64'(rd_err), 0);
        check("full_max_ost", 64'(max_ost), 4);

        // AR stall: payload must hold while arready is low.
        do_reset("rst1");
        ar_rdy_en = 1'b0;
        enable    = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("stall_arvalid%0d", i), 64'(axi.arvalid), 1);
            check($sformatf("stall_arid%0d", i), 64'(axi.arid), 0);
            check($sformatf("stall_araddr%0d", i), 64'(axi.araddr), 0);
        end
        ar_rdy_en = 1'b1;
        run_to_done("stall", 34);
        check("stall_err", 64'(rd_err), 0);

        // R withheld: four outstanding blocks AR until the first burst pops.
        do_reset("rst2");
        r_en   = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 20 && ar_cnt < 4; i++) step();
        check("full_ar_cnt", 64'(ar_cnt), 4);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("full_arvalid%0d", i), 64'(axi.arvalid), 0);
        end
        r_en = 1'b1;
        step();
        check("reissue_arvalid", 64'(axi.arvalid), 1);
        check("reissue_arid", 64'(axi.arid), 4);
        check("reissue_araddr", 64'(axi.araddr), 64'h100);
        run_to_done("ost", 34);
        check("ost_err", 64'(rd_err), 0);

        // SLVERR on the second (last) beat of request 1.
        do_reset("rst3");
        inj_kind = 1;
        inj_req  = 1;
        inj_beat = 1;
        enable   = 1'b1;
        run_to_done("slverr", 34);
        check("slverr_seen", 64'(inj_seen), 1);
        check("slverr_sticky", 64'(rd_err), 1);

        // Early RLAST on beat 0 of request 2 (arlen 2); that burst ends after one beat.
        do_reset("rst4");
        inj_kind = 2;
        inj_req  = 2;
        inj_beat = 0;
        enable   = 1'b1;
        run_to_done("rlast", 32);
        check("rlast_seen", 64'(inj_seen), 1);
        check("rlast_err", 64'(rd_err), 1);

        // Asynchronous reset in the middle of request 3, then a clean restart.
        do_reset("rst5");
        enable = 1'b1;
        for (int i = 0; i < 100 && !(rq.size() > 0 && rq[0].k == 3 && beat_idx >= 1); i++) step();
        check("reach_req3", 64'(rq.size() > 0 && rq[0].k == 3 && beat_idx >= 1), 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        clear_model();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        check("restart_arvalid", 64'(axi.arvalid), 1);
        check("restart_arid", 64'(axi.arid), 0);
        check("restart_araddr", 64'(axi.araddr), 0);
        run_to_done("restart", 34);
        check("restart_err", 64'(rd_err), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", n_checks, n_errs);
        $fatal(1);
    end

endmodule
